// File: rtl/io_port_if.sv
// Request/acknowledge bus between the datapath and the I/O responder, plus the
// board-side output stream and input strobe.
interface io_port_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        ack;
  logic [15:0] rdata;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        in_strobe;
  logic [15:0] in_word;

  modport slave (
    input  req, we, addr, wdata, out_ready, in_strobe, in_word,
    output ack, rdata, out_valid, out_data
  );

  modport master (
    output req, we, addr, wdata, out_ready, in_strobe, in_word,
    input  ack, rdata, out_valid, out_data
  );
endinterface

// File: rtl/io_port_responder.sv
// Memory-mapped I/O responder: output FIFO, latched input word and a cycle timer
// behind a 4-register window, answering req/ack accesses from the datapath.
module io_port_responder #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] IO_BASE    = 16'hFF00
) (
  input  logic     clk,
  input  logic     rst_n,
  io_port_if.slave bus
);

  localparam int                PTR_W   = $clog2(FIFO_DEPTH);
  localparam int                CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DECODE     = 2'd1,
    WAIT_SPACE = 2'd2,
    RESPOND    = 2'd3
  } state_t;

  state_t           state_r;
  logic             we_r;
  logic [15:0]      addr_r;
  logic [15:0]      wdata_r;
  logic             ack_r;
  logic [15:0]      rdata_r;

  logic [15:0]      mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_r;
  logic [PTR_W-1:0] rptr_r;
  logic [CNT_W-1:0] count_r;
  logic             out_valid_r;
  logic [15:0]      out_data_r;

  logic [15:0]      in_reg_r;
  logic             in_valid_r;
  logic             overrun_r;
  logic [15:0]      timer_r;

  logic [15:0]      off_s;
  logic             in_win_s;
  logic             full_s;
  logic             empty_s;
  logic             pop_s;
  logic             push_s;
  logic             stall_s;
  logic             rd_status_s;
  logic             rd_in_s;
  logic             wr_timer_s;
  logic [15:0]      rdata_nxt_s;
  logic [PTR_W-1:0] wptr_nxt_s;
  logic [PTR_W-1:0] rptr_nxt_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic [15:0]      out_data_nxt_s;

  assign bus.ack       = ack_r;
  assign bus.rdata     = rdata_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;

  // Address decode of the latched request and read-data selection
  always_comb begin
    off_s       = addr_r - IO_BASE;
    in_win_s    = (off_s < 16'd4);
    full_s      = (count_r == DEPTH_C);
    empty_s     = (count_r == {CNT_W{1'b0}});
    pop_s       = !empty_s && bus.out_ready;
    stall_s     = (state_r == DECODE) && we_r && in_win_s && (off_s[1:0] == 2'd0) && full_s;
    // A WAIT_SPACE push may coincide with a pop that frees the slot
    push_s      = ((state_r == DECODE) && we_r && in_win_s && (off_s[1:0] == 2'd0) && !full_s) ||
                  ((state_r == WAIT_SPACE) && (!full_s || pop_s));
    rd_status_s = (state_r == DECODE) && !we_r && in_win_s && (off_s[1:0] == 2'd1);
    rd_in_s     = (state_r == DECODE) && !we_r && in_win_s && (off_s[1:0] == 2'd2);
    wr_timer_s  = (state_r == DECODE) && we_r && in_win_s && (off_s[1:0] == 2'd3);
    rdata_nxt_s = 16'h0000;
    if (in_win_s && !we_r) begin
      case (off_s[1:0])
        2'd0:    rdata_nxt_s = {13'b0, count_r};
        2'd1:    rdata_nxt_s = {9'b0, count_r, overrun_r, in_valid_r, empty_s, full_s};
        2'd2:    rdata_nxt_s = in_reg_r;
        2'd3:    rdata_nxt_s = timer_r;
        default: rdata_nxt_s = 16'h0000;
      endcase
    end else begin
      rdata_nxt_s = 16'h0000;
    end
  end

  // FIFO pointer/count next state and the head word presented after the edge
  always_comb begin
    wptr_nxt_s = push_s ? (wptr_r + PTR_W'(1)) : wptr_r;
    rptr_nxt_s = pop_s  ? (rptr_r + PTR_W'(1)) : rptr_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
    if (count_nxt_s == {CNT_W{1'b0}}) begin
      out_data_nxt_s = 16'h0000;
    end else if (push_s && (rptr_nxt_s == wptr_r)) begin
      out_data_nxt_s = wdata_r;
    end else begin
      out_data_nxt_s = mem_r[rptr_nxt_s];
    end
  end

  // Request/acknowledge sequencer with registered ack and read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      we_r    <= 1'b0;
      addr_r  <= 16'h0000;
      wdata_r <= 16'h0000;
      ack_r   <= 1'b0;
      rdata_r <= 16'h0000;
    end else begin
      case (state_r)
        IDLE: begin
          ack_r   <= 1'b0;
          rdata_r <= 16'h0000;
          if (bus.req) begin
            we_r    <= bus.we;
            addr_r  <= bus.addr;
            wdata_r <= bus.wdata;
            state_r <= DECODE;
          end else begin
            state_r <= IDLE;
          end
        end
        DECODE: begin
          if (stall_s) begin
            state_r <= WAIT_SPACE;
          end else begin
            ack_r   <= 1'b1;
            rdata_r <= rdata_nxt_s;
            state_r <= RESPOND;
          end
        end
        WAIT_SPACE: begin
          if (push_s) begin
            ack_r   <= 1'b1;
            rdata_r <= 16'h0000;
            state_r <= RESPOND;
          end else begin
            state_r <= WAIT_SPACE;
          end
        end
        RESPOND: begin
          ack_r   <= 1'b0;
          rdata_r <= 16'h0000;
          state_r <= IDLE;
        end
        default: begin
          ack_r   <= 1'b0;
          rdata_r <= 16'h0000;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Output FIFO storage and registered stream outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 16'h0000;
      end
      wptr_r      <= {PTR_W{1'b0}};
      rptr_r      <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= 16'h0000;
    end else begin
      if (push_s) begin
        mem_r[wptr_r] <= wdata_r;
      end
      wptr_r      <= wptr_nxt_s;
      rptr_r      <= rptr_nxt_s;
      count_r     <= count_nxt_s;
      out_valid_r <= (count_nxt_s != {CNT_W{1'b0}});
      out_data_r  <= out_data_nxt_s;
    end
  end

  // Input latch: a strobe always wins over a clearing read in the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_reg_r   <= 16'h0000;
      in_valid_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      if (bus.in_strobe) begin
        in_reg_r   <= bus.in_word;
        in_valid_r <= 1'b1;
      end else if (rd_in_s) begin
        in_valid_r <= 1'b0;
      end
      if (bus.in_strobe && in_valid_r) begin
        overrun_r <= 1'b1;
      end else if (rd_status_s) begin
        overrun_r <= 1'b0;
      end
    end
  end

  // Free-running cycle timer, loadable from the TIMER register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_r <= 16'h0000;
    end else if (wr_timer_s) begin
      timer_r <= wdata_r;
    end else begin
      timer_r <= timer_r + 16'd1;
    end
  end

endmodule

// File: tb/tb_io_port_responder.sv
// Bench for io_port_responder: directed register-map scenarios followed by
// randomized accesses checked against a queue/formula-based reference model.
module tb_io_port_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  io_port_if bus();

  io_port_responder #(.FIFO_DEPTH(4), .IO_BASE(16'hFF00)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state
  logic [15:0] mq[$];
  logic [15:0] m_in = 16'h0000;
  bit          m_iv = 1'b0;
  bit          m_ov = 1'b0;
  logic [15:0] t_base = 16'h0000;
  int          t_edge = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [15:0] m_status();
    logic [2:0] c3;
    c3 = 3'(mq.size());
    return {9'b0, c3, m_ov, m_iv, (mq.size() == 0), (mq.size() == 4)};
  endfunction

  // Timer value just before edge d: base plus edges elapsed since it was loaded
  function automatic logic [15:0] m_timer(input int d);
    return t_base + 16'(d - t_edge - 1);
  endfunction

  task automatic m_strobe(input logic [15:0] w);
    if (m_iv) m_ov = 1'b1;
    m_in = w;
    m_iv = 1'b1;
  endtask

  task automatic m_reset();
    mq.delete();
    m_in = 16'h0000;
    m_iv = 1'b0;
    m_ov = 1'b0;
  endtask

  task automatic m_access(input logic w, input logic [15:0] a, input logic [15:0] d,
                          input bit sdec, input logic [15:0] sword, input int dedge,
                          output logic [15:0] exp);
    logic [15:0] off;
    bit old_iv;
    old_iv = m_iv;
    off = a - 16'hFF00;
    exp = 16'h0000;
    if (off < 16'd4) begin
      case (off[1:0])
        2'd0: if (w) mq.push_back(d); else exp = {13'b0, 3'(mq.size())};
        2'd1: if (!w) begin exp = m_status(); m_ov = 1'b0; end
        2'd2: if (!w) begin exp = m_in; m_iv = 1'b0; end
        2'd3: if (w) begin t_base = d; t_edge = dedge; end else exp = m_timer(dedge);
        default: exp = 16'h0000;
      endcase
    end
    if (sdec) begin
      if (old_iv) m_ov = 1'b1;
      m_in = sword;
      m_iv = 1'b1;
    end
  endtask

  task automatic drive_req(input logic w, input logic [15:0] a, input logic [15:0] d);
    bus.req = 1'b1;
    bus.we = w;
    bus.addr = a;
    bus.wdata = d;
  endtask

  // One bus access; optionally pulses in_strobe so it lands on the decode edge
  task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                        input bit sdec, input logic [15:0] sword,
                        output logic [15:0] rd, output int lat, output int dedge);
    drive_req(w, a, d);
    lat = 0;
    rd = 16'h0000;
    dedge = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (sdec && n == 1) begin bus.in_strobe = 1'b1; bus.in_word = sword; end
      if (n == 2) bus.in_strobe = 1'b0;
      if (bus.ack) begin lat = n; rd = bus.rdata; dedge = edge_cnt; break; end
    end
    if (lat == 0) chk("ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.req = 1'b0;
    bus.in_strobe = 1'b0;
    chk("ack_pulse", {31'b0, bus.ack}, 32'd0);
  endtask

  task automatic xact(input string tag, input logic w, input logic [15:0] a, input logic [15:0] d,
                      input bit sdec, input logic [15:0] sword, output logic [15:0] rd);
    int lat, dedge;
    logic [15:0] exp;
    access(w, a, d, sdec, sword, rd, lat, dedge);
    m_access(w, a, d, sdec, sword, dedge, exp);
    chk({tag, "_rd"}, {16'b0, rd}, {16'b0, exp});
    chk({tag, "_lat"}, lat, 32'd2);
  endtask

  task automatic idle_cycle(input bit rdy, input bit stb, input logic [15:0] w);
    logic [15:0] hd;
    hd = 16'h0000;
    if (mq.size() != 0) hd = mq[0];
    bus.out_ready = rdy;
    bus.in_strobe = stb;
    bus.in_word = w;
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, (mq.size() != 0)});
    chk("out_data", {16'b0, bus.out_data}, {16'b0, hd});
    @(posedge clk);
    if (rdy && mq.size() != 0) void'(mq.pop_front());
    if (stb) m_strobe(w);
    #1;
    bus.out_ready = 1'b0;
    bus.in_strobe = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic [15:0] a;
    logic w;
    int off;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = 16'h0000; bus.wdata = 16'h0000;
    bus.out_ready = 1'b0; bus.in_strobe = 1'b0; bus.in_word = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'b0, bus.ack}, 32'd0);
    chk("rst_rdata", {16'b0, bus.rdata}, 32'd0);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_out_data", {16'b0, bus.out_data}, 32'd0);
    rst_n = 1'b1;
    m_reset();
    t_base = 16'h0000;
    t_edge = edge_cnt;

    xact("status_rst", 1'b0, 16'hFF01, 16'h0000, 1'b0, 16'h0000, rd);
    chk("status_rst_lit", {16'b0, rd}, 32'h0002);
    xact("timer_rst", 1'b0, 16'hFF03, 16'h0000, 1'b0, 16'h0000, rd);

    // Fill the FIFO, then stall a fifth push until one pop frees a slot
    for (int k = 1; k <= 4; k++)
      xact("push", 1'b1, 16'hFF00, 16'(16'h1111 * k), 1'b0, 16'h0000, rd);
    xact("status_full", 1'b0, 16'hFF01, 16'h0000, 1'b0, 16'h0000, rd);
    chk("status_full_lit", {16'b0, rd}, 32'h0041);
    drive_req(1'b1, 16'hFF00, 16'h5555);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("stall_no_ack", {31'b0, bus.ack}, 32'd0);
    end
    chk("stall_head", {16'b0, bus.out_data}, 32'h1111);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("stall_ack", {31'b0, bus.ack}, 32'd1);
    void'(mq.pop_front());
    mq.push_back(16'h5555);
    @(posedge clk); #1;
    bus.req = 1'b0;
    xact("status_full2", 1'b0, 16'hFF01, 16'h0000, 1'b0, 16'h0000, rd);
    chk("status_full2_lit", {16'b0, rd}, 32'h0041);
    for (int k = 0; k < 4; k++) begin
      chk("drain_lit", {16'b0, bus.out_data}, {16'b0, 16'(16'h1111 * (k + 2))});
      idle_cycle(1'b1, 1'b0, 16'h0000);
    end
    idle_cycle(1'b0, 1'b0, 16'h0000);

    // Input latch, overrun and same-edge strobe interactions
    idle_cycle(1'b0, 1'b1, 16'hABCD);
    idle_cycle(1'b0, 1'b1, 16'h1234);
    xact("status_ov", 1'b0, 16'hFF01, 16'h0000, 1'b0, 16'h0000, rd);
    chk("status_ov_lit", {16'b0, rd}, 32'h000E);
    xact("in_rd", 1'b0, 16'hFF02, 16'h0000, 1'b0, 16'h0000, rd);
    chk("in_rd_lit", {16'b0, rd}, 32'h1234);
    xact("status_clr", 1'b0, 16'hFF01, 16'h0000, 1'b0, 16'h0000, rd);
    xact("status_idle", 1'b0, 16'hFF01, 16'h0000, 1'b0, 16'h0000, rd);
    chk("status_idle_lit", {16'b0, rd}, 32'h0002);
    idle_cycle(1'b0, 1'b1, 16'h5A5A);
    xact("in_rd_same", 1'b0, 16'hFF02, 16'h0000, 1'b1, 16'h0F0F, rd);
    chk("in_rd_same_lit", {16'b0, rd}, 32'h5A5A);
    xact("status_same", 1'b0, 16'hFF01, 16'h0000, 1'b1, 16'h7777, rd);
    xact("status_set_wins", 1'b0, 16'hFF01, 16'h0000, 1'b0, 16'h0000, rd);
    chk("status_set_wins_lit", {16'b0, rd}, 32'h000E);
    xact("in_rd_new", 1'b0, 16'hFF02, 16'h0000, 1'b0, 16'h0000, rd);
    xact("status_ov_clr", 1'b0, 16'hFF01, 16'h0000, 1'b0, 16'h0000, rd);

    // Timer load and wrap through zero
    xact("timer_wr", 1'b1, 16'hFF03, 16'hFFFE, 1'b0, 16'h0000, rd);
    xact("timer_wrap", 1'b0, 16'hFF03, 16'h0000, 1'b0, 16'h0000, rd);
    chk("timer_wrap_lit", {16'b0, rd}, 32'h0000);

    // Out-of-window accesses leave all state untouched
    xact("oow_seed", 1'b1, 16'hFF00, 16'hBEEF, 1'b0, 16'h0000, rd);
    idle_cycle(1'b0, 1'b1, 16'hC0DE);
    xact("oow_wr", 1'b1, 16'h0010, 16'h1234, 1'b0, 16'h0000, rd);
    xact("oow_rd", 1'b0, 16'hFF10, 16'h0000, 1'b0, 16'h0000, rd);
    chk("oow_rd_lit", {16'b0, rd}, 32'h0000);
    xact("oow_status", 1'b0, 16'hFF01, 16'h0000, 1'b0, 16'h0000, rd);
    xact("oow_timer", 1'b0, 16'hFF03, 16'h0000, 1'b0, 16'h0000, rd);
    xact("oow_in", 1'b0, 16'hFF02, 16'h0000, 1'b0, 16'h0000, rd);
    idle_cycle(1'b1, 1'b0, 16'h0000);

    // Reset while stalled in WAIT_SPACE
    for (int k = 0; k < 4; k++)
      xact("fill", 1'b1, 16'hFF00, 16'(16'hA000 + k), 1'b0, 16'h0000, rd);
    drive_req(1'b1, 16'hFF00, 16'h9999);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_stall_no_ack", {31'b0, bus.ack}, 32'd0);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ack", {31'b0, bus.ack}, 32'd0);
    chk("rst_mid_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_mid_out_data", {16'b0, bus.out_data}, 32'd0);
    bus.req = 1'b0;
    m_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    t_base = 16'h0000;
    t_edge = edge_cnt;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_no_ack", {31'b0, bus.ack}, 32'd0);
    end
    xact("post_rst_status", 1'b0, 16'hFF01, 16'h0000, 1'b0, 16'h0000, rd);
    chk("post_rst_status_lit", {16'b0, rd}, 32'h0002);
    xact("post_rst_count", 1'b0, 16'hFF00, 16'h0000, 1'b0, 16'h0000, rd);
    xact("post_rst_timer", 1'b0, 16'hFF03, 16'h0000, 1'b0, 16'h0000, rd);

    // Randomized traffic against the reference model
    for (int it = 0; it < 200; it++) begin
      for (int j = 0; j < int'($urandom_range(0, 3)); j++)
        idle_cycle(1'($urandom % 2), ($urandom % 4) == 0, 16'($urandom));
      off = int'($urandom_range(0, 4));
      w = 1'($urandom % 2);
      if (off < 4) a = 16'hFF00 + 16'(off);
      else a = 16'($urandom_range(0, 32'h0000FEFF));
      if (w && off == 0 && mq.size() == 4) w = 1'b0;
      xact("rnd", w, a, 16'($urandom), ($urandom % 6) == 0, 16'($urandom), rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
